btn_debounce: RTL and testbench
===============================

# btn_debounce

Upstream conditioning stage for the three-event detector. It takes a raw, asynchronous, bouncy push-button signal and synchronises it into `Clk`. It qualifies each level change over a programmable number of stable cycles. It emits exactly one single-cycle `Pulse` per accepted press, and that pulse drives the detector's `In` directly. A debounced `Level` and a single-cycle `Release` pulse are also provided for other consumers.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised samples at the new level required to accept a change. Legal range is 2 .. 2^`CNT_WIDTH`−1.
- `CNT_WIDTH`, default 3: width of the stability counter.
- `Clk`  input  1  sole clock; all state changes on its rising edge.
- `Rst`  input  1  reset; asynchronous, active-high. Clears all state immediately on assertion, independent of `Clk`.
- `Btn`  input  1  raw button, asynchronous to `Clk`, may bounce.
- `Pulse`  output  1  registered; high for exactly one cycle per accepted press (0→1).
- `Release`  output  1  registered; high for exactly one cycle per accepted release (1→0).
- `Level`  output  1  registered debounced button level.

## Operation
- Synchroniser: two flops, `Btn`→`sync0`→`sync1`, both reset to 0. Only `sync1` is used downstream.
- FSM: 2-bit state, reset to LOW. Counter `cnt` is `CNT_WIDTH` bits and resets to 0.
  - LOW: if `sync1`=1, go to RISE_CHK and set `cnt`=1. Otherwise hold and set `cnt`=0.
  - RISE_CHK:
    - If `sync1`=0, go to LOW and set `cnt`=0 (glitch rejected, no output change).
    - Else if `cnt`==`STABLE_CYCLES`−1, go to HIGH, set `cnt`=0, `Level`<=1, `Pulse`<=1.
    - Else `cnt`<=`cnt`+1.
  - HIGH: if `sync1`=0, go to FALL_CHK and set `cnt`=1. Otherwise hold.
  - FALL_CHK:
    - If `sync1`=1, go to HIGH and set `cnt`=0 (no output change).
    - Else if `cnt`==`STABLE_CYCLES`−1, go to LOW, set `cnt`=0, `Level`<=0, `Release`<=1.
    - Else `cnt`<=`cnt`+1.
- `Pulse` and `Release` default to 0 every cycle unless set by the transitions above. Neither can be high two cycles in a row.
- `Pulse` and `Release` are never high in the same cycle.
- A change is accepted only after exactly `STABLE_CYCLES` consecutive `sync1` samples at the new level: one in LOW or HIGH, then `STABLE_CYCLES`−1 in the CHK state.
- `cnt` never exceeds `STABLE_CYCLES`−1, so no wrap-around is possible.
- Holding the button indefinitely produces a single `Pulse`. There is no auto-repeat.

## Timing
- Reset values: `Pulse`=0, `Release`=0, `Level`=0, state=LOW, `cnt`=0, `sync0`=`sync1`=0.
- `Rst` asserted mid-qualification (either CHK state) or while HIGH:
  - All outputs go to 0 immediately.
  - No `Release` is emitted.
  - After `Rst` deasserts, a button still held is re-qualified from LOW and yields a fresh `Pulse`.
- Press latency: `Btn` rises and is stable before rising edge k.
  - `sync1`=1 after edge k+1.
  - `Pulse` and `Level` go high after edge k+1+`STABLE_CYCLES`.
  - `Pulse` drops after the next edge.
  - With defaults, `Pulse` is high in the cycle following edge k+5.
- Release latency is identical: `Release` high and `Level` low after edge k+1+`STABLE_CYCLES` from a stable fall.
- Minimum accepted press: `STABLE_CYCLES` cycles high as seen at `sync1`. Shorter highs produce no output.
- Minimum spacing between two `Pulse`s is 2·`STABLE_CYCLES` cycles.

## Test plan
- Reset values and async reset: assert `Rst` between clock edges. All outputs and state clear without a clock edge. After release with `Btn`=0, outputs stay 0 for 20 cycles.
- Clean press (defaults): `Btn` rises before edge 10 and is held 12 cycles. `Pulse`=1 only in the cycle after edge 15, `Level`=1 from edge 15. `Btn` falls before edge 22, giving `Release`=1 only in the cycle after edge 27 and `Level`=0 from edge 27.
- Bounce rejection:
  - `Btn` pattern 1,1,0,1,1,1,0 (cycles): no `Pulse`, `Level` stays 0.
  - With `Level`=1, a 3-cycle low glitch: no `Release`, `Level` stays 1.
- Bouncy press then stable hold: glitches 1,0,1,0 followed by 8 cycles high produce exactly one `Pulse`, issued 4 stable `sync1` samples after the last bounce.
- Reset mid-qualification: `Btn` held high, `Rst` pulsed while in RISE_CHK with `cnt`=2. No `Pulse` appears before reset. After `Rst` deasserts, exactly one `Pulse` follows 6 edges later (2 synchroniser + 4 qualify).
- Integration: `btn_debounce.Pulse` wired to detector `In`. Three clean presses of 6 cycles high and 6 low set detector `Out`=1 after the third `Pulse`. A burst of 10 short glitches leaves `Out`=0.

Source files
------------

// File: rtl/btn_debounce_if.sv
// Push-button conditioning bus: raw button in, debounced level and edge pulses out.
// The debouncer takes the slave side and the button source takes the master side.
interface btn_debounce_if;
  logic Btn;
  logic Pulse;
  logic Release;
  logic Level;

  modport master (output Btn, input Pulse, input Release, input Level);
  modport slave  (input Btn, output Pulse, output Release, output Level);
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: two-flop synchroniser followed by a four-state stability FSM.
// It emits one-cycle Pulse/Release strobes on each accepted edge and a debounced Level.
module btn_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    st_low      = 2'd0,
    st_rise_chk = 2'd1,
    st_high     = 2'd2,
    st_fall_chk = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync0;
  logic                 sync1;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 pulse_q;
  logic                 release_q;
  logic                 level_q;

  // NOTE: Btn is asynchronous. Only sync1 may be looked at, because sync0 can still be metastable.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= bus.Btn;
      sync1 <= sync0;
    end
  end

  // cnt counts the samples already seen at the new level, so reaching CNT_LAST
  // while the level still holds is the STABLE_CYCLES-th consecutive sample.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= st_low;
      cnt       <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      // NOTE: the strobes default low here and a later assignment in the same block overrides this, which is what makes them single-cycle.
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state)
        st_low: begin
          if (sync1) begin
            state <= st_rise_chk;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        st_rise_chk: begin
          if (!sync1) begin
            state <= st_low;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= st_high;
            cnt     <= '0;
            level_q <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        st_high: begin
          if (!sync1) begin
            state <= st_fall_chk;
            cnt   <= CNT_ONE;
          end
        end
        st_fall_chk: begin
          if (sync1) begin
            state <= st_high;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= st_low;
            cnt       <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= st_low;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.Pulse   = pulse_q;
  assign bus.Release = release_q;
  assign bus.Level   = level_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: a per-cycle vector table plus hand-written
// reset sequences. Expected outputs are packed as {Pulse, Release, Level}.
module tb_btn_debounce;

  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  btn_debounce_if bus ();

  btn_debounce #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       btn;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic b, input logic p, input logic r, input logic l, input int n);
    vec_t v;
    v.btn = b;
    v.exp = {p, r, l};
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] act;
    act = {bus.Pulse, bus.Release, bus.Level};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pulse/rel/lvl=%b want %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Rst     = 1'b1;
    bus.Btn = 1'b0;

    // Entry n is the Btn value driven before edge n and the outputs expected just after edge n.
    add(1, 0, 0, 0, 5);   // clean press: qualification in progress
    add(1, 1, 0, 1, 1);   // Pulse at k+1+STABLE_CYCLES
    add(1, 0, 0, 1, 6);   // held, no auto-repeat
    add(0, 0, 0, 1, 5);   // falling edge being qualified
    add(0, 0, 1, 0, 1);   // Release
    add(0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1);   // bounce 1,1,0,1,1,1,0 is rejected
    add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 1);   // bouncy press 1,0,1,0 then stable high
    add(0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 5);
    add(1, 1, 0, 1, 1);   // single Pulse, 4 stable samples after last bounce
    add(1, 0, 0, 1, 2);
    add(0, 0, 0, 1, 3);   // 3-cycle low glitch while Level=1
    add(1, 0, 0, 1, 10);  // no Release, Level stays 1
    add(0, 0, 0, 1, 5);
    add(0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 4);   // shortest press that is accepted: exactly 4 high
    add(0, 0, 0, 0, 1);
    add(0, 1, 0, 1, 1);
    add(0, 0, 0, 1, 3);
    add(0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 2);

    // Async reset: clear from Level=1 between clock edges.
    repeat (2) tick();
    Rst = 1'b0;
    check("reset_idle", 3'b000);
    bus.Btn = 1'b1;
    repeat (8) tick();
    check("warm_level", 3'b001);
    #2 Rst = 1'b1;
    #1 check("async_rst_no_edge", 3'b000);
    bus.Btn = 1'b0;
    #2 Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("post_rst_idle%0d", i), 3'b000);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      bus.Btn = tbl[i].btn;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset while in RISE_CHK with cnt=2 and the button still held.
    bus.Btn = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("midq_pre%0d", e), 3'b000);
    end
    #2 Rst = 1'b1;
    #1 check("midq_rst", 3'b000);
    #2 Rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("midq_post%0d", e), (e == 6) ? 3'b101 : (e == 7) ? 3'b001 : 3'b000);
    end

    // Reset while HIGH: Level drops at once, no Release, and a fresh Pulse follows.
    #2 Rst = 1'b1;
    #1 check("high_rst", 3'b000);
    #2 Rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("high_post%0d", e), (e == 6) ? 3'b101 : (e == 7) ? 3'b001 : 3'b000);
    end

    bus.Btn = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      check($sformatf("final_rel%0d", e), (e < 5) ? 3'b001 : (e == 5) ? 3'b010 : 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
